// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer: direct select or round-robin auto-scan
// with a programmable dwell of DIV enabled clocks per channel.
module mux_scan_n #(
  parameter int WIDTH = 32,
  parameter int CH    = 8,
  parameter int SELW  = $clog2(CH),
  parameter int DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   din,
  input  logic                  mode,
  input  logic [SELW-1:0]       s,
  input  logic                  en,
  output logic [WIDTH-1:0]      o,
  output logic [SELW-1:0]       o_sel,
  output logic                  o_valid,
  output logic                  wrap
);

  localparam int PREW = (DIV > 1) ? $clog2(DIV) : 1;

  logic                 mode_q;
  logic [SELW-1:0]      ptr_q, ptr_d, ptr_n;
  logic [PREW-1:0]      pre_q, pre_d;
  logic [WIDTH-1:0]     o_q, o_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;

  function automatic logic in_range(input logic [SELW-1:0] k);
    return int'(k) < CH;
  endfunction

  // Out-of-range channel indices read as zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] d,
                                            input logic [SELW-1:0] k);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(k) == i) r = d[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    ptr_n   = ptr_q;
    ptr_d   = ptr_q;
    pre_d   = pre_q;
    o_d     = o_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (mode) begin
      if (!mode_q) begin
        ptr_n = in_range(s) ? s : '0;
        pre_d = '0;
      end else if (int'(pre_q) == DIV - 1) begin
        pre_d  = '0;
        wrap_d = (int'(ptr_q) == CH - 1);
        ptr_n  = wrap_d ? '0 : ptr_q + SELW'(1);
      end else begin
        pre_d = pre_q + PREW'(1);
      end
      ptr_d   = ptr_n;
      o_d     = pick(din, ptr_n);
      sel_d   = ptr_n;
      valid_d = 1'b1;
    end else begin
      o_d     = pick(din, s);
      sel_d   = s;
      valid_d = in_range(s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      ptr_q   <= '0;
      pre_q   <= '0;
      o_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      mode_q  <= mode;
      ptr_q   <= ptr_d;
      pre_q   <= pre_d;
      o_q     <= o_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  // A held wrap must not show while the block is frozen.
  assign wrap    = wrap_q & en;
  assign o       = o_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: direct/range/scan/enable/reset/data cases
// on three builds (CH=8 DIV=4, CH=6 DIV=2, CH=8 DIV=1).
module tb_mux_scan_n;

  typedef struct {
    logic        mode;
    logic [2:0]  s;
    logic        en;
    logic [31:0] o;
    logic [2:0]  sel;
    logic        valid;
    logic        wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  logic [255:0] din_a, din_c;
  logic [191:0] din_b;
  logic mode_a = 0, mode_b = 0, mode_c = 0;
  logic en_a = 1, en_b = 1, en_c = 1;
  logic [2:0] s_a = 0, s_b = 0, s_c = 0;
  logic [31:0] o_a, o_b, o_c;
  logic [2:0] sel_a, sel_b, sel_c;
  logic v_a, v_b, v_c, w_a, w_b, w_c;

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(32), .CH(8), .DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .mode(mode_a), .s(s_a), .en(en_a),
    .o(o_a), .o_sel(sel_a), .o_valid(v_a), .wrap(w_a));
  mux_scan_n #(.WIDTH(32), .CH(6), .DIV(2)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .mode(mode_b), .s(s_b), .en(en_b),
    .o(o_b), .o_sel(sel_b), .o_valid(v_b), .wrap(w_b));
  mux_scan_n #(.WIDTH(32), .CH(8), .DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din_c), .mode(mode_c), .s(s_c), .en(en_c),
    .o(o_c), .o_sel(sel_c), .o_valid(v_c), .wrap(w_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic m, input int sv, input logic e,
                              input int sel, input logic w);
    vec_t v;
    v.mode = m; v.s = 3'(sv); v.en = e;
    v.o = 32'(sel); v.sel = 3'(sel); v.valid = 1'b1; v.wrap = w;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[24];
    bit reached;

    tbl[0]  = mk(0, 5, 1, 5, 0);
    tbl[1]  = mk(1, 5, 1, 5, 0);
    tbl[2]  = mk(1, 5, 1, 5, 0);
    tbl[3]  = mk(1, 5, 1, 5, 0);
    tbl[4]  = mk(1, 5, 1, 5, 0);
    tbl[5]  = mk(1, 5, 1, 6, 0);
    tbl[6]  = mk(1, 5, 1, 6, 0);
    tbl[7]  = mk(1, 5, 1, 6, 0);
    tbl[8]  = mk(1, 5, 1, 6, 0);
    tbl[9]  = mk(1, 5, 1, 7, 0);
    tbl[10] = mk(1, 5, 1, 7, 0);
    tbl[11] = mk(1, 5, 1, 7, 0);
    tbl[12] = mk(1, 5, 1, 7, 0);
    tbl[13] = mk(1, 5, 1, 0, 1);
    tbl[14] = mk(1, 5, 0, 0, 0);
    tbl[15] = mk(1, 5, 1, 0, 0);
    tbl[16] = mk(1, 5, 1, 0, 0);
    tbl[17] = mk(1, 5, 1, 0, 0);
    tbl[18] = mk(1, 5, 1, 1, 0);
    tbl[19] = mk(1, 5, 1, 1, 0);
    tbl[20] = mk(1, 5, 1, 1, 0);
    tbl[21] = mk(1, 5, 1, 1, 0);
    tbl[22] = mk(1, 5, 1, 2, 0);
    tbl[23] = mk(1, 5, 1, 2, 0);

    for (int k = 0; k < 8; k++) begin
      din_a[k*32 +: 32] = 32'(k);
      din_c[k*32 +: 32] = 32'(k);
    end
    for (int k = 0; k < 6; k++) din_b[k*32 +: 32] = 32'(k);

    // Reset state
    #12;
    chk("rst_o", o_a, 0);
    chk("rst_sel", 32'(sel_a), 0);
    chk("rst_valid", 32'(v_a), 0);
    chk("rst_wrap", 32'(w_a), 0);
    rst_n = 1'b1;

    // T1 direct
    for (int sv = 7; sv >= 0; sv--) begin
      s_a = 3'(sv);
      for (int c = 0; c < 10; c++) begin
        tick();
        chk("t1_o", o_a, 32'(sv));
        chk("t1_sel", 32'(sel_a), 32'(sv));
      end
      chk("t1_valid", 32'(v_a), 1);
    end

    // T3 scan (table)
    for (int i = 0; i < 24; i++) begin
      mode_a = tbl[i].mode; s_a = tbl[i].s; en_a = tbl[i].en;
      tick();
      chk($sformatf("t3_o[%0d]", i), o_a, tbl[i].o);
      chk($sformatf("t3_sel[%0d]", i), 32'(sel_a), 32'(tbl[i].sel));
      chk($sformatf("t3_valid[%0d]", i), 32'(v_a), 32'(tbl[i].valid));
      chk($sformatf("t3_wrap[%0d]", i), 32'(w_a), 32'(tbl[i].wrap));
    end

    // T4 enable freeze on ch2 with pre=1
    en_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_frz_sel", 32'(sel_a), 2);
      chk("t4_frz_o", o_a, 2);
      chk("t4_frz_wrap", 32'(w_a), 0);
    end
    en_a = 1'b1;
    tick(); chk("t4_run1", 32'(sel_a), 2);
    tick(); chk("t4_run2", 32'(sel_a), 2);
    tick(); chk("t4_next", 32'(sel_a), 3);

    // T5 asynchronous reset mid-scan at ch6
    reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      tick();
      if (sel_a == 3'd6) reached = 1;
    end
    chk("t5_reach6", 32'(reached), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_o", o_a, 0);
    chk("t5_sel", 32'(sel_a), 0);
    chk("t5_valid", 32'(v_a), 0);
    chk("t5_wrap", 32'(w_a), 0);
    tick();
    rst_n = 1'b1;
    s_a = 3'd4;
    tick();
    chk("t5_entry_sel", 32'(sel_a), 4);
    chk("t5_entry_o", o_a, 4);
    chk("t5_entry_valid", 32'(v_a), 1);
    tick();
    chk("t5_dwell", 32'(sel_a), 4);

    // T6 data follow on ch3
    mode_a = 1'b0;
    s_a = 3'd3;
    tick();
    mode_a = 1'b1;
    tick();
    chk("t6_entry", o_a, 3);
    din_a[3*32 +: 32] = 32'hDEADBEEF;
    tick();
    chk("t6_o", o_a, 32'hDEADBEEF);
    chk("t6_sel", 32'(sel_a), 3);
    din_a[3*32 +: 32] = 32'd3;

    // T2 range on CH=6
    s_b = 3'd6;
    tick();
    chk("t2_o6", o_b, 0); chk("t2_v6", 32'(v_b), 0); chk("t2_sel6", 32'(sel_b), 6);
    s_b = 3'd7;
    tick();
    chk("t2_o7", o_b, 0); chk("t2_v7", 32'(v_b), 0); chk("t2_sel7", 32'(sel_b), 7);
    s_b = 3'd5;
    tick();
    chk("t2_o5", o_b, 5); chk("t2_v5", 32'(v_b), 1);
    s_b = 3'd7;
    mode_b = 1'b1;
    tick();
    chk("t2_entry_sel", 32'(sel_b), 0); chk("t2_entry_v", 32'(v_b), 1);
    tick(); chk("t2_dwell", 32'(sel_b), 0);
    tick(); chk("t2_step", 32'(sel_b), 1);

    // DIV=1 build: advances every enabled clock
    s_c = 3'd3;
    tick();
    mode_c = 1'b1;
    tick();
    chk("d1_entry", 32'(sel_c), 3);
    chk("d1_entry_wrap", 32'(w_c), 0);
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk("d1_sel", 32'(sel_c), 32'(k % 8));
      chk("d1_o", o_c, 32'(k % 8));
      chk("d1_wrap", 32'(w_c), (k == 8) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
